// File: rtl/conv_mac_pipe.sv
// Pipelined signed dot-product engine: TAPS products, registered adder tree, framed accumulator.
// Define MAC_PIPE_SAT_EN to clamp results into OUT_W with out_ovf; otherwise results wrap.
module conv_mac_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned TAPS   = 9,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned OUT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic [TAPS*DATA_W-1:0]    in_data,
  input  logic [TAPS*COEF_W-1:0]    in_coef,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_ovf
);

  localparam int unsigned P  = DATA_W + COEF_W;
  localparam int unsigned L  = (TAPS > 1) ? $clog2(TAPS) : 0;
  localparam int unsigned SW = P + L;

  function automatic int unsigned node_cnt(int unsigned lv);
    return (TAPS + (32'(1) << lv) - 1) >> lv;
  endfunction

  logic w_stall;
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

  // Level 0 holds the products; each further level adds pairs and grows one bit.
  for (genvar lv = 0; lv <= L; lv++) begin : g_lvl
    localparam int unsigned NW = P + lv;
    localparam int unsigned NN = node_cnt(lv);
    for (genvar n = 0; n < NN; n++) begin : g_node
      logic signed [NW-1:0] r_node;
      if (lv == 0) begin : g_mul
        logic signed [P-1:0] w_prod;
        assign w_prod = P'($signed(in_data[n*DATA_W +: DATA_W]))
                      * P'($signed(in_coef[n*COEF_W +: COEF_W]));
        always_ff @(posedge clk or posedge rst) begin
          if (rst)           r_node <= '0;
          else if (!w_stall) r_node <= w_prod;
        end
      end else if (2*n+1 < node_cnt(lv-1)) begin : g_add
        always_ff @(posedge clk or posedge rst) begin
          if (rst)           r_node <= '0;
          else if (!w_stall) r_node <= NW'(g_lvl[lv-1].g_node[2*n].r_node)
                                     + NW'(g_lvl[lv-1].g_node[2*n+1].r_node);
        end
      end else begin : g_pass
        always_ff @(posedge clk or posedge rst) begin
          if (rst)           r_node <= '0;
          else if (!w_stall) r_node <= NW'(g_lvl[lv-1].g_node[2*n].r_node);
        end
      end
    end
  end

  logic signed [SW-1:0] w_sum;
  assign w_sum = g_lvl[L].g_node[0].r_node;

  // Valid and framing flags ride alongside the product/tree levels.
  logic [L:0] r_vld, r_fst, r_lst;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_fst <= '0;
      r_lst <= '0;
    end else if (!w_stall) begin
      r_vld[0] <= in_valid;
      r_fst[0] <= in_first;
      r_lst[0] <= in_last;
      for (int i = 1; i <= int'(L); i++) begin
        r_vld[i] <= r_vld[i-1];
        r_fst[i] <= r_fst[i-1];
        r_lst[i] <= r_lst[i-1];
      end
    end
  end

  // Accumulator; a beat following a last always restarts the sum.
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_acc_rdy;
  logic                    r_restart;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_acc_rdy <= 1'b0;
      r_restart <= 1'b0;
    end else if (!w_stall) begin
      r_acc_rdy <= r_vld[L] && r_lst[L];
      if (r_vld[L]) begin
        r_acc     <= (r_fst[L] || r_restart) ? ACC_W'(w_sum) : r_acc + ACC_W'(w_sum);
        r_restart <= r_lst[L];
      end
    end
  end

  logic [OUT_W-1:0] w_out_c;
  logic             w_ovf_c;
`ifdef MAC_PIPE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  always_comb begin
    w_out_c = r_acc[OUT_W-1:0];
    w_ovf_c = 1'b0;
    if (r_acc > SAT_MAX) begin
      w_out_c = {1'b0, {(OUT_W-1){1'b1}}};
      w_ovf_c = 1'b1;
    end else if (r_acc < SAT_MIN) begin
      w_out_c = {1'b1, {(OUT_W-1){1'b0}}};
      w_ovf_c = 1'b1;
    end
  end
`else
  assign w_out_c = r_acc[OUT_W-1:0];
  assign w_ovf_c = 1'b0;
`endif

  // Output register; a pending result pops and a new one loads on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (!w_stall) begin
      out_valid <= r_acc_rdy;
      if (r_acc_rdy) begin
        out_data <= w_out_c;
        out_ovf  <= w_ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Bench for conv_mac_pipe: table-driven frames, scoreboard queue, latency/stall/reset sequences.
module tb_conv_mac_pipe;
  localparam int unsigned DW = 8, CW = 8, T = 9, AW = 40, OW = 32, OW2 = 16;
`ifdef MAC_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_ready2, in_first, in_last;
  logic [T*DW-1:0] in_data;
  logic [T*CW-1:0] in_coef;
  logic out_valid, out_ready, out_ovf, out_valid2, out_ovf2;
  logic [OW-1:0]  out_data;
  logic [OW2-1:0] out_data2;

  always #5 clk = ~clk;

  conv_mac_pipe #(.DATA_W(DW), .COEF_W(CW), .TAPS(T), .ACC_W(AW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_data(in_data), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf));

  conv_mac_pipe #(.DATA_W(DW), .COEF_W(CW), .TAPS(T), .ACC_W(AW), .OUT_W(OW2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_first(in_first), .in_last(in_last), .in_data(in_data), .in_coef(in_coef),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ovf(out_ovf2));

  typedef struct {
    logic signed [7:0] d;
    logic signed [7:0] c;
    bit                alt;
    bit                first;
    bit                last;
    longint            exp;
  } vec_t;

  vec_t   tbl[13];
  longint q[$];
  int     n_cmp = 0, n_bad = 0;
  int     pushed = 0, popped = 0;
  bit     stall_arm = 1'b0;
  int     stall_left = 0;
  logic [OW-1:0] held;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic longint lim_hi(input int w);
    return (64'sd1 <<< (w-1)) - 1;
  endfunction
  function automatic longint lim_lo(input int w);
    return -(64'sd1 <<< (w-1));
  endfunction

  function automatic longint conv(input longint v, input int w);
    longint m;
    if (SAT) return (v > lim_hi(w)) ? lim_hi(w) : ((v < lim_lo(w)) ? lim_lo(w) : v);
    m = v & ((64'sd1 <<< w) - 1);
    if (m > lim_hi(w)) m = m - (64'sd1 <<< w);
    return m;
  endfunction

  function automatic longint ovf(input longint v, input int w);
    return (SAT && (v > lim_hi(w) || v < lim_lo(w))) ? 1 : 0;
  endfunction

  // Drive one beat, wait for acceptance, and push the expected result on a last beat.
  task automatic drive(input logic signed [7:0] d, input logic signed [7:0] c,
                       input bit alt, input bit first, input bit last, input longint exp);
    bit ok;
    logic signed [7:0] v;
    ok = 1'b0;
    @(negedge clk);
    for (int i = 0; i < int'(T); i++) begin
      v = (alt && (i % 2 == 1)) ? -d : d;
      in_data[i*DW +: DW] = v;
      in_coef[i*CW +: CW] = c;
    end
    in_first = first;
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      #2;
      ok = in_ready;
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
    end else if (last) begin
      q.push_back(exp);
      pushed++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (q.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
    repeat (10) @(negedge clk);
  endtask

  // Output side: drives out_ready, applies stall windows, pops and checks results.
  initial begin
    longint e;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        out_ready = 1'b1;
        continue;
      end
      if (stall_arm && out_valid) begin
        stall_arm  = 1'b0;
        stall_left = 5;
        held       = out_data;
      end
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        stall_left--;
        check("stall_in_ready", longint'(in_ready), 0);
        check("stall_hold", longint'(out_data), longint'(held));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_out: got result %0d, required none", $signed(out_data));
        end else begin
          e = q.pop_front();
          popped++;
          check("out_data", longint'($signed(out_data)), conv(e, OW));
          check("out_ovf", longint'(out_ovf), ovf(e, OW));
          check("out_valid16", longint'(out_valid2), 1);
          check("out_data16", longint'($signed(out_data2)), conv(e, OW2));
          check("out_ovf16", longint'(out_ovf2), ovf(e, OW2));
        end
      end
    end
  end

  initial begin
    int n;
    tbl[0]  = '{d:  8'sd1,   c:  8'sd2,   alt: 0, first: 1, last: 1, exp: 18};
    tbl[1]  = '{d: -8'sd128, c:  8'sd127, alt: 0, first: 1, last: 1, exp: -146304};
    tbl[2]  = '{d:  8'sd1,   c:  8'sd2,   alt: 0, first: 1, last: 0, exp: 0};
    tbl[3]  = '{d:  8'sd1,   c:  8'sd2,   alt: 0, first: 0, last: 0, exp: 0};
    tbl[4]  = '{d:  8'sd1,   c:  8'sd2,   alt: 0, first: 0, last: 1, exp: 54};
    tbl[5]  = '{d:  8'sd5,   c:  8'sd1,   alt: 1, first: 1, last: 1, exp: 5};
    tbl[6]  = '{d:  8'sd127, c:  8'sd127, alt: 0, first: 1, last: 1, exp: 145161};
    tbl[7]  = '{d: -8'sd128, c: -8'sd128, alt: 0, first: 1, last: 1, exp: 147456};
    tbl[8]  = '{d:  8'sd7,   c: -8'sd3,   alt: 1, first: 1, last: 1, exp: -21};
    tbl[9]  = '{d: -8'sd128, c:  8'sd127, alt: 0, first: 1, last: 0, exp: 0};
    tbl[10] = '{d: -8'sd128, c: -8'sd128, alt: 0, first: 0, last: 1, exp: 1152};
    tbl[11] = '{d:  8'sd3,   c:  8'sd3,   alt: 0, first: 0, last: 1, exp: 81};
    tbl[12] = '{d:  8'sd0,   c:  8'sd0,   alt: 0, first: 1, last: 1, exp: 0};

    rst = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_data = '0; in_coef = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_ovf", longint'(out_ovf), 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_in_ready", longint'(in_ready), 1);

    // Latency of a single-beat frame and one-cycle output pulse.
    drive(8'sd1, 8'sd2, 1'b0, 1'b1, 1'b1, 18);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      n = k;
      if (out_valid) break;
    end
    check("latency", longint'(n), 7);
    @(negedge clk);
    #1;
    check("valid_one_cycle", longint'(out_valid), 0);
    drain();

    // Back-to-back table frames.
    for (int i = 0; i < 13; i++)
      drive(tbl[i].d, tbl[i].c, tbl[i].alt, tbl[i].first, tbl[i].last, tbl[i].exp);
    idle();
    drain();

    // Continuous single-beat frames with a 5-cycle output stall.
    stall_arm = 1'b1;
    for (int k = 0; k < 10; k++)
      drive(8'(k + 1), 8'sd1, 1'b0, 1'b1, 1'b1, 9 * (k + 1));
    idle();
    drain();
    check("stall_popped", longint'(popped), longint'(pushed));

    // Reset in the middle of a three-beat frame, then a clean frame.
    drive(8'sd1, 8'sd2, 1'b0, 1'b1, 1'b0, 0);
    drive(8'sd1, 8'sd2, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_out_data", longint'(out_data), 0);
    check("abort_out_ovf", longint'(out_ovf), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(8'sd1, 8'sd2, 1'b0, 1'b1, 1'b1, 18);
    idle();
    drain();
    check("final_queue_empty", longint'(q.size()), 0);
    check("final_popped", longint'(popped), longint'(pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_mac_pipe.md
# conv_mac_pipe

Parametrised, fully pipelined dot-product engine for the convolver: TAPS signed data×coefficient products per beat, reduced through a registered binary adder tree and accumulated across beats (input channels) under first/last framing. Sits between the line-buffer window generator and the convolver output/activation stage. Valid/ready handshake on both sides with global stall. It replaces the fixed 3×3, enable-gated MAC.

## Interface
- DATA_W, 8, signed data element width
- COEF_W, 8, signed coefficient width
- TAPS, 9, products per beat (≥1; 9 = 3×3, 25 = 5×5)
- ACC_W, 40, accumulator width; must be ≥ DATA_W+COEF_W+ceil(log2(TAPS))
- OUT_W, 32, result width; must be ≤ ACC_W

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_first  in  1  beat starts a new accumulation
- in_last  in  1  beat ends accumulation; produces a result
- in_data  in  TAPS*DATA_W  packed signed data, tap i at [i*DATA_W +: DATA_W]
- in_coef  in  TAPS*COEF_W  packed signed coefficients, same packing
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  OUT_W  signed result
- out_ovf  out  1  result was clamped (0 when saturation compiled out)

## Operation
- Stage M: TAPS registered signed products, width P = DATA_W+COEF_W.
- Stages T1..TL, L = ceil(log2(TAPS)): pairwise-add tree, one register level per stage; odd leftover passes through registered; each level grows width by 1; all signed, sign-extended.
- Stage A: accumulator ACC_W. On beat flagged first: acc = sum. Otherwise acc = acc + sum (two's-complement wrap at ACC_W). first && last on one beat: result = that beat's sum.
- On last: acc result goes to the output register; out_valid=1. Non-last beats produce no output. The beat after a last is treated as first even if in_first=0.
- A beat with first=0 before any first after reset accumulates onto acc=0.
- Valid bit and first/last flags travel with each stage.
- Output conversion: see Configuration.

## Timing
- Reset: every valid bit, acc, out_data, out_valid and out_ovf are 0; in_ready=1 one cycle after rst deasserts. In-flight beats and partial accumulation are discarded. No output is produced for an aborted frame.
- Stall = out_valid && !out_ready. in_ready = !stall. While stalled, all stages hold, including acc and out_data.
- Latency from accept of a last beat to out_valid: L+3 cycles (M, L tree stages, A, output). TAPS=9 gives 7 cycles.
- Throughput: one beat per cycle, one result per frame, no bubbles when out_ready=1.
- out_ready=1 while a new result arrives: old result pops and new result loads in the same edge.
- Results appear in frame order. out_data and out_ovf are stable while out_valid && !out_ready.

## Configuration
- MAC_PIPE_SAT_EN defined: the accumulator value outside [−2^(OUT_W−1), 2^(OUT_W−1)−1] clamps to the nearest bound with out_ovf=1. Otherwise out_ovf=0.
- Undefined: out_data = acc[OUT_W-1:0] (truncate/wrap); out_ovf tied 0; no compare logic.

## Test plan
- Defaults. All data=1, coef=2, single beat first=last=1 -> out_data=18, out_valid exactly 7 cycles after accept, for one cycle with out_ready=1.
- Defaults. Data=−128, coef=127 on all taps, single beat -> out_data=−146304.
- Three-beat frame, each beat sum 18 (first on beat 0, last on beat 2), back-to-back with a second single-beat frame of sum 5 -> outputs 54 then 5; no output for beats 0–1.
- Continuous beats with out_ready held 0 for 5 cycles after the first result -> in_ready=0 the cycle after out_valid rises; all results delivered later in order, none lost or duplicated.
- OUT_W=16, data=coef=127 on 9 taps (sum 145161) -> with MAC_PIPE_SAT_EN: out_data=32767, out_ovf=1. Without it: out_data=14089, out_ovf=0.
- Assert rst during the middle beat of a 3-beat frame -> all outputs 0. The next frame of sum 18 returns exactly 18, with no residue from the aborted frame.
